// File: rtl/packer_stream_arbiter.sv
// Frame-granular round-robin arbiter sharing one data_packer between two AXI-Stream sources.
// Optional stall timeout (and its timeout output) is enabled by defining ARB_TIMEOUT_EN.
module packer_stream_arbiter #(
  parameter int DATA_WIDTH     = 8,
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
  input  logic                  s0_axis_tvalid,
  output logic                  s0_axis_tready,
  input  logic                  s0_axis_tlast,
  input  logic [1:0]            s0_k,
  input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
  input  logic                  s1_axis_tvalid,
  output logic                  s1_axis_tready,
  input  logic                  s1_axis_tlast,
  input  logic [1:0]            s1_k,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [1:0]            k_out,
  output logic [1:0]            grant,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  frame_beats,
`ifdef ARB_TIMEOUT_EN
  output logic                  timeout,
`endif
  output logic                  cfg_err
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_FWD  = 1'b1;

  logic       state;
  logic       last_served;
  logic       accept;
  logic       pick;
  logic [1:0] sel_k;

  // With both sources requesting, the one not served last wins.
  assign pick  = (s0_axis_tvalid && s1_axis_tvalid) ? ~last_served : s1_axis_tvalid;
  assign sel_k = pick ? s1_k : s0_k;

  // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
  always_comb begin
    m_axis_tdata   = '0;
    m_axis_tvalid  = 1'b0;
    m_axis_tlast   = 1'b0;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    if (state == ST_FWD) begin
      if (grant[1]) begin
        m_axis_tdata   = s1_axis_tdata;
        m_axis_tvalid  = s1_axis_tvalid;
        m_axis_tlast   = s1_axis_tlast;
        s1_axis_tready = m_axis_tready;
      end else begin
        m_axis_tdata   = s0_axis_tdata;
        m_axis_tvalid  = s0_axis_tvalid;
        m_axis_tlast   = s0_axis_tlast;
        s0_axis_tready = m_axis_tready;
      end
    end
  end

  assign accept = m_axis_tvalid && m_axis_tready;
  assign busy   = (state == ST_FWD);

`ifdef ARB_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [STALL_W-1:0] stall_cnt;

  // Fires during the TIMEOUT_CYCLES-th consecutive cycle without a handshake.
  assign timeout = (state == ST_FWD) && !accept &&
                   (stall_cnt == STALL_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (state == ST_IDLE || accept) begin
      stall_cnt <= '0;
    end else if (!timeout) begin
      stall_cnt <= stall_cnt + STALL_W'(1);
    end
  end
`endif

  // NOTE: state is updated with non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      grant       <= 2'b00;
      last_served <= 1'b1;
      k_out       <= 2'd1;
      frame_beats <= '0;
      cfg_err     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (s0_axis_tvalid || s1_axis_tvalid) begin
            state       <= ST_FWD;
            grant       <= pick ? 2'b10 : 2'b01;
            frame_beats <= '0;
            if (sel_k == 2'd0) begin
              k_out   <= 2'd1;
              cfg_err <= 1'b1;
            end else begin
              k_out <= sel_k;
            end
          end
        end
        default: begin
          if (accept) begin
            if (frame_beats != '1) frame_beats <= frame_beats + CNT_WIDTH'(1);
            if (m_axis_tlast) begin
              state       <= ST_IDLE;
              grant       <= 2'b00;
              last_served <= grant[1];
            end
          end
`ifdef ARB_TIMEOUT_EN
          else if (timeout) begin
            state       <= ST_IDLE;
            grant       <= 2'b00;
            last_served <= grant[1];
          end
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_packer_stream_arbiter.sv
// Scoreboard bench for packer_stream_arbiter: stimulus queues expected beats, a negedge monitor checks them.
module tb_packer_stream_arbiter;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic [1:0] k;
    logic [1:0] grant;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  s_data  [2];
  logic        s_valid [2];
  logic        s_last  [2];
  logic [1:0]  s_k     [2];
  logic        s_ready [2];
  logic [7:0]  m_data;
  logic        m_valid, m_last, mready;
  logic [1:0]  k_out, grant;
  logic        busy, cfg_err;
  logic [15:0] frame_beats;
`ifdef ARB_TIMEOUT_EN
  logic        timeout;
`endif

  int    checks = 0;
  int    errors = 0;
  beat_t exp_q[$];

  always #5 clk = ~clk;

  packer_stream_arbiter #(.DATA_WIDTH(8), .CNT_WIDTH(16), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .s0_axis_tdata(s_data[0]), .s0_axis_tvalid(s_valid[0]), .s0_axis_tready(s_ready[0]),
    .s0_axis_tlast(s_last[0]), .s0_k(s_k[0]),
    .s1_axis_tdata(s_data[1]), .s1_axis_tvalid(s_valid[1]), .s1_axis_tready(s_ready[1]),
    .s1_axis_tlast(s_last[1]), .s1_k(s_k[1]),
    .m_axis_tdata(m_data), .m_axis_tvalid(m_valid), .m_axis_tready(mready),
    .m_axis_tlast(m_last), .k_out(k_out), .grant(grant), .busy(busy),
    .frame_beats(frame_beats),
`ifdef ARB_TIMEOUT_EN
    .timeout(timeout),
`endif
    .cfg_err(cfg_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: every handshake on the master side consumes one expected beat.
  always @(negedge clk) begin
    if (reset && m_valid && mready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat at %0t: got data %0h expected none", $time, m_data);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        check("beat_data", m_data, e.data);
        check("beat_last", m_last, e.last);
        check("beat_k", k_out, e.k);
        check("beat_grant", grant, e.grant);
        check("other_tready", s_ready[e.grant == 2'b01 ? 1 : 0], 1'b0);
      end
    end
  end

  task automatic push_frame(input int src, input logic [1:0] k, input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++)
      exp_q.push_back('{data: base + 8'(i), last: (i == n - 1),
                        k: (k == 2'd0) ? 2'd1 : k, grant: (src == 1) ? 2'b10 : 2'b01});
  endtask

  task automatic drive_beat(input int src, input logic [7:0] d, input logic last, input logic [1:0] k);
    bit hs = 1'b0;
    s_valid[src] = 1'b1;
    s_data[src]  = d;
    s_last[src]  = last;
    s_k[src]     = k;
    for (int c = 0; c < 200 && !hs; c++) begin
      @(negedge clk);
      hs = s_ready[src];
      @(posedge clk);
      #1;
    end
    if (!hs) begin
      checks++;
      errors++;
      $display("FAIL beat_wait src%0d: got no handshake expected one within 200 cycles", src);
    end
  endtask

  task automatic send_frame(input int src, input logic [1:0] k, input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) drive_beat(src, base + 8'(i), (i == n - 1), k);
    s_valid[src] = 1'b0;
    s_last[src]  = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      s_data[i] = '0; s_valid[i] = 1'b0; s_last[i] = 1'b0; s_k[i] = 2'd1;
    end
    mready = 1'b1;
    apply_reset();

    // Reset state
    check("rst_grant", grant, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_s0_tready", s_ready[0], 1'b0);
    check("rst_s1_tready", s_ready[1], 1'b0);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_last", m_last, 1'b0);
    check("rst_m_data", m_data, 8'h00);
    check("rst_k_out", k_out, 2'd1);
    check("rst_frame_beats", frame_beats, 16'd0);
    check("rst_cfg_err", cfg_err, 1'b0);

    // Single source, 4-beat frame, one-cycle arbitration latency
    push_frame(0, 2'd2, 4, 8'h00);
    fork
      send_frame(0, 2'd2, 4, 8'h00);
      begin
        @(negedge clk);
        check("t1_grant_before", grant, 2'b00);
        @(posedge clk); #1;
        check("t1_grant_after", grant, 2'b01);
        check("t1_k_out", k_out, 2'd2);
        check("t1_busy", busy, 1'b1);
      end
    join
    check("t1_grant_end", grant, 2'b00);
    check("t1_busy_end", busy, 1'b0);
    check("t1_frame_beats", frame_beats, 16'd4);

    // Both sources valid continuously: grants alternate starting with s0
    apply_reset();
    push_frame(0, 2'd1, 3, 8'h10);
    push_frame(1, 2'd3, 3, 8'h20);
    push_frame(0, 2'd1, 3, 8'h30);
    push_frame(1, 2'd3, 3, 8'h40);
    fork
      begin send_frame(0, 2'd1, 3, 8'h10); send_frame(0, 2'd1, 3, 8'h30); end
      begin send_frame(1, 2'd3, 3, 8'h20); send_frame(1, 2'd3, 3, 8'h40); end
    join
    check("t2_k_held_idle", k_out, 2'd3);
    check("t2_frame_beats", frame_beats, 16'd3);

    // Back-pressure pattern 1,0,0,1,1 on a 3-beat frame
    mready = 1'b0;
    push_frame(0, 2'd3, 3, 8'h70);
    fork
      send_frame(0, 2'd3, 3, 8'h70);
      begin
        logic pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
          mready = pat[i];
          @(negedge clk);
          check("t3_tready_mirror", s_ready[0], pat[i]);
          @(posedge clk); #1;
        end
        mready = 1'b1;
      end
    join
    check("t3_frame_beats", frame_beats, 16'd3);

    // k = 0 is coerced to 1 and flags a sticky config error
    push_frame(1, 2'd0, 2, 8'h80);
    send_frame(1, 2'd0, 2, 8'h80);
    @(posedge clk); #1;
    check("t4_cfg_err_sticky", cfg_err, 1'b1);
    check("t4_k_out", k_out, 2'd1);

    // Asynchronous reset mid-frame
    push_frame(0, 2'd2, 2, 8'h50);
    exp_q[1].last = 1'b0;
    drive_beat(0, 8'h50, 1'b0, 2'd2);
    drive_beat(0, 8'h51, 1'b0, 2'd2);
    s_data[0] = 8'h52;
    #1 reset = 1'b0;
    #1;
    check("t5_grant", grant, 2'b00);
    check("t5_busy", busy, 1'b0);
    check("t5_m_valid", m_valid, 1'b0);
    check("t5_s0_tready", s_ready[0], 1'b0);
    check("t5_k_out", k_out, 2'd1);
    check("t5_frame_beats", frame_beats, 16'd0);
    check("t5_cfg_err", cfg_err, 1'b0);
    check("t5_queue_drained", exp_q.size(), 0);
    s_valid[0] = 1'b0;
    #3 reset = 1'b1;
    @(posedge clk); #1;
    push_frame(1, 2'd2, 2, 8'h60);
    send_frame(1, 2'd2, 2, 8'h60);
    check("t5_frame_beats_after", frame_beats, 16'd2);

`ifdef ARB_TIMEOUT_EN
    // s0 stalls after grant; timeout fires on the 8th stall cycle, pending s1 wins next
    apply_reset();
    s_valid[0] = 1'b1; s_data[0] = 8'h90; s_last[0] = 1'b0; s_k[0] = 2'd1;
    @(posedge clk); #1;
    check("t6_grant_s0", grant, 2'b01);
    s_valid[0] = 1'b0;
    s_valid[1] = 1'b1; s_data[1] = 8'hA0; s_last[1] = 1'b1; s_k[1] = 2'd2;
    push_frame(1, 2'd2, 1, 8'hA0);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      check("t6_timeout", timeout, (c == 8));
      @(posedge clk); #1;
    end
    check("t6_grant_idle", grant, 2'b00);
    check("t6_timeout_low", timeout, 1'b0);
    @(posedge clk); #1;
    check("t6_grant_s1", grant, 2'b10);
    @(posedge clk); #1;
    s_valid[1] = 1'b0;
    s_last[1]  = 1'b0;
    check("t6_frame_beats", frame_beats, 16'd1);
`endif

    repeat (2) @(posedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/packer_stream_arbiter.md
Name: packer_stream_arbiter

Overview:
- Shares one data_packer instance between two AXI-Stream sources with frame-granular round-robin arbitration.
- Latches each winning source's packing factor and drives it to the packer's k input; k stays constant for the whole frame.
- Sits directly upstream of data_packer: m_axis_* feeds the packer's s_axis_* and k_out feeds its k input.

Parameters:
- DATA_WIDTH, 8, tdata width of both sources and the master port.
- CNT_WIDTH, 16, width of the per-frame beat counter.
- TIMEOUT_CYCLES, 64, stall limit used only when ARB_TIMEOUT_EN is defined.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- s0_axis_tdata  in  DATA_WIDTH  source 0 data.
- s0_axis_tvalid  in  1  source 0 valid.
- s0_axis_tready  out  1  source 0 ready.
- s0_axis_tlast  in  1  source 0 end of frame.
- s0_k  in  2  source 0 packing factor; sampled only at grant.
- s1_axis_tdata / s1_axis_tvalid / s1_axis_tready / s1_axis_tlast / s1_k  same as source 0, for source 1.
- m_axis_tdata  out  DATA_WIDTH  to the packer.
- m_axis_tvalid  out  1  to the packer.
- m_axis_tready  in  1  from the packer.
- m_axis_tlast  out  1  to the packer.
- k_out  out  2  packing factor to the packer.
- grant  out  2  one-hot active source, 00 when idle.
- busy  out  1  high while a frame is granted.
- frame_beats  out  CNT_WIDTH  beats accepted in the current or last frame.
- cfg_err  out  1  sticky; set when a granted source presents k = 0.

Behaviour:
- Reset (reset = 0, async): state IDLE; grant = 00; busy = 0; all tready = 0; m_axis_tvalid = 0; m_axis_tlast = 0; m_axis_tdata = 0; k_out = 2'd1; frame_beats = 0; cfg_err = 0; last_served = 1, so source 0 wins first.
- Reset mid-frame aborts the frame with no tlast emitted; the downstream packer shares the same reset.
- State IDLE:
  - All tready = 0; m_axis_* = 0.
  - If exactly one s*_tvalid = 1, grant that source.
  - If both are valid, grant the source != last_served.
  - On grant, at the next edge: k_out <= granted s_k, grant <= one-hot, busy <= 1, frame_beats <= 0, state -> FWD.
  - Arbitration latency is 1 cycle from tvalid to first possible transfer.
- k coercion: if the sampled s_k == 0, k_out <= 1 and cfg_err <= 1. cfg_err clears only on reset.
- State FWD (combinational pass-through, zero latency):
  - m_axis_tdata, tvalid and tlast follow the granted source.
  - granted s_tready = m_axis_tready; the non-granted tready = 0.
- Beat accepted (m_axis_tvalid & m_axis_tready): frame_beats increments, saturating at all-ones.
- Accepted beat with tlast = 1: at that edge, last_served <= granted index, grant <= 00, busy <= 0, state -> IDLE.
  - One bubble cycle between frames is mandatory.
  - frame_beats holds its final value until the next grant.
- k_out changes only on the IDLE->FWD edge; it holds its value while idle.
- The non-granted source's tvalid and tlast are ignored. Its data must stay pending, with no transfer.
- tlast on the first beat is legal and gives a 1-beat frame.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - Stall counter, cleared on every accepted beat and on grant; increments each FWD cycle with no accepted beat.
  - On reaching TIMEOUT_CYCLES: extra output port timeout pulses high for 1 cycle, state -> IDLE, last_served <= current grant (rotates priority), grant <= 00. No tlast is injected.
  - timeout reset value is 0.
- Undefined: no timeout port, no counter; FWD waits indefinitely for tlast.

Test Plan:
- Only s0 valid, s0_k = 2, 4-beat frame 0x00..0x03, m_axis_tready = 1 -> grant = 01 one cycle after tvalid, k_out = 2, 4 beats pass through in order, tlast on 0x03, frame_beats = 4, grant = 00 next cycle.
- s0 and s1 both valid continuously, 3-beat frames, s0_k = 1, s1_k = 3 -> grants alternate 01, 10, 01, ...; k_out toggles 1/3 only at grant edges; s1_tready = 0 throughout s0 frames.
- Granted frame with m_axis_tready toggling 1,0,0,1 -> granted tready mirrors it, no beat lost or duplicated, frame_beats counts only handshakes.
- s1 sole requester with s1_k = 0 -> k_out = 1, cfg_err = 1 and stays set after the frame completes.
- Reset pulled low at beat 2 of a 5-beat frame -> all outputs at reset values immediately, without waiting for a clock edge; after release, an s1-only request is granted normally.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 8, s0 granted then tvalid held 0 -> timeout pulses on the 8th stall cycle, grant = 00, and a pending s1 is granted next.
